metaframe_scrambler: RTL and testbench

METAFRAME_SCRAMBLER -- requirements
Module: metaframe_scrambler

---
 rtl/metaframe_scrambler_if.sv | 19 +
 rtl/metaframe_scrambler.sv | 91 +++++++++
 tb/tb_metaframe_scrambler.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/metaframe_scrambler_if.sv
// metaframe_scrambler_if: payload-in / scrambled-out stream bundle for the metaframe scrambler.
interface metaframe_scrambler_if #(parameter int TX_DATA_WIDTH = 64);
    logic                     PASSTHROUGH;
    logic [TX_DATA_WIDTH-1:0] DATA_IN;
    logic [1:0]               HEADER_IN;
    logic                     DATA_IN_VALID;
    logic                     DATA_IN_READY;
    logic [TX_DATA_WIDTH-1:0] DATA_OUT;
    logic [1:0]               HEADER_OUT;
    logic                     DATA_OUT_VALID;
    modport master (
        output PASSTHROUGH, DATA_IN, HEADER_IN, DATA_IN_VALID,
        input  DATA_IN_READY, DATA_OUT, HEADER_OUT, DATA_OUT_VALID
    );
    modport slave (
        input  PASSTHROUGH, DATA_IN, HEADER_IN, DATA_IN_VALID,
        output DATA_IN_READY, DATA_OUT, HEADER_OUT, DATA_OUT_VALID
    );
endinterface

// File: rtl/metaframe_scrambler.sv
// metaframe_scrambler: sync/state/payload metaframer with x^58+x^39+1 self-synchronous scrambler.
// Define METAFRAME_SCRAMBLER_ERR_INJECT_EN to add INJECT_SYNC_ERR (flips bit 0 of the next sync word).
module metaframe_scrambler #(
    parameter int          TX_DATA_WIDTH  = 64,
    parameter logic [63:0] SYNC_WORD      = 64'h78f678f678f678f6,
    parameter int          META_FRAME_LEN = 16
) (
    input logic USER_CLK,
    input logic SYSTEM_RESET,
`ifdef METAFRAME_SCRAMBLER_ERR_INJECT_EN
    input logic INJECT_SYNC_ERR,
`endif
    metaframe_scrambler_if.slave bus
);
    localparam int CW = $clog2(META_FRAME_LEN);
    typedef enum logic [1:0] {SYNC, STATE, PAYLOAD} state_t;
    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [57:0]              scr;
    logic [57:0]              scr_next;
    logic [TX_DATA_WIDTH-1:0] scrambled;
    logic [63:0]              sync_out;
    logic                     last;
    assign bus.DATA_IN_READY = SYSTEM_RESET ? 1'b0 : bus.PASSTHROUGH ? 1'b1 : state == PAYLOAD;
    assign last = cnt == CW'(META_FRAME_LEN - 3);
    // Bit-serial scrambling, LSB first, feeding each output bit back into the state.
    always_comb begin
        scr_next = scr;
        scrambled = '0;
        for (int i = 0; i < TX_DATA_WIDTH; i++) begin
            scrambled[i] = bus.DATA_IN[i] ^ scr_next[38] ^ scr_next[57];
            scr_next = {scr_next[56:0], scrambled[i]};
        end
    end
`ifdef METAFRAME_SCRAMBLER_ERR_INJECT_EN
    logic err_flag;
    assign sync_out = SYNC_WORD ^ {63'd0, err_flag};
    // A pulse arriving in the same cycle the corrupted sync goes out is kept for the next one.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET)
            err_flag <= 1'b0;
        else if (!bus.PASSTHROUGH && state == SYNC)
            err_flag <= INJECT_SYNC_ERR;
        else
            err_flag <= err_flag | INJECT_SYNC_ERR;
    end
`else
    assign sync_out = SYNC_WORD;
`endif
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state              <= SYNC;
            cnt                <= '0;
            scr                <= '1;
            bus.DATA_OUT       <= '0;
            bus.HEADER_OUT     <= 2'b00;
            bus.DATA_OUT_VALID <= 1'b0;
        end else if (bus.PASSTHROUGH) begin
            state              <= SYNC;
            cnt                <= '0;
            bus.DATA_OUT       <= bus.DATA_IN;
            bus.HEADER_OUT     <= bus.HEADER_IN;
            bus.DATA_OUT_VALID <= bus.DATA_IN_VALID;
        end else begin
            case (state)
                SYNC: begin
                    state              <= STATE;
                    bus.DATA_OUT       <= sync_out;
                    bus.HEADER_OUT     <= 2'b10;
                    bus.DATA_OUT_VALID <= 1'b1;
                end
                STATE: begin
                    state              <= PAYLOAD;
                    bus.DATA_OUT       <= {6'b001010, scr};
                    bus.HEADER_OUT     <= 2'b10;
                    bus.DATA_OUT_VALID <= 1'b1;
                end
                default: begin
                    bus.DATA_OUT_VALID <= bus.DATA_IN_VALID;
                    if (bus.DATA_IN_VALID) begin
                        scr            <= scr_next;
                        cnt            <= last ? '0 : cnt + 1'b1;
                        state          <= last ? SYNC : PAYLOAD;
                        bus.DATA_OUT   <= scrambled;
                        bus.HEADER_OUT <= bus.HEADER_IN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_metaframe_scrambler.sv
// tb_metaframe_scrambler: directed bench; payload words are recovered with an independent
// self-synchronising descrambler seeded from the emitted state word.
module tb_metaframe_scrambler;
    localparam logic [63:0] SYNC  = 64'h78f678f678f678f6;
    localparam logic [63:0] STATE0 = 64'h2BFFFFFFFFFFFFFF;
    logic USER_CLK = 1'b0;
    logic SYSTEM_RESET;
    int checks = 0;
    int errors = 0;
    logic [57:0] mscr;
    logic [63:0] sent;
    logic [63:0] got;
`ifdef METAFRAME_SCRAMBLER_ERR_INJECT_EN
    logic INJECT_SYNC_ERR = 1'b0;
`endif
    metaframe_scrambler_if #(.TX_DATA_WIDTH(64)) bus ();
    metaframe_scrambler dut (
        .USER_CLK(USER_CLK),
        .SYSTEM_RESET(SYSTEM_RESET),
`ifdef METAFRAME_SCRAMBLER_ERR_INJECT_EN
        .INJECT_SYNC_ERR(INJECT_SYNC_ERR),
`endif
        .bus(bus)
    );
    always #5 USER_CLK = ~USER_CLK;

    task automatic tick;
        @(posedge USER_CLK);
        #1;
    endtask

    task automatic descramble(input logic [63:0] w, output logic [63:0] d);
        for (int i = 0; i < 64; i++) begin
            d[i] = w[i] ^ mscr[38] ^ mscr[57];
            mscr = {mscr[56:0], w[i]};
        end
    endtask

    // Accept one payload word and verify it descrambles back to what was sent.
    task automatic payload_word(input logic [63:0] w, input logic [1:0] h);
        bus.DATA_IN = w;
        bus.HEADER_IN = h;
        bus.DATA_IN_VALID = 1'b1;
        tick;
        descramble(bus.DATA_OUT, got);
        checks++;
        if (got !== w || bus.HEADER_OUT !== h || bus.DATA_OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL payload got %h/%b/%b exp %h/%b/1", got, bus.HEADER_OUT, bus.DATA_OUT_VALID, w, h);
        end
    endtask

    task automatic test_reset;
        SYSTEM_RESET = 1'b1;
        bus.PASSTHROUGH = 1'b1;
        bus.DATA_IN_VALID = 1'b1;
        bus.DATA_IN = 64'hFFFF_0000_FFFF_0000;
        bus.HEADER_IN = 2'b11;
        tick;
        tick;
        checks++;
        if (bus.DATA_OUT !== 64'd0 || bus.HEADER_OUT !== 2'b00 || bus.DATA_OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%b/%b exp 0/00/0", bus.DATA_OUT, bus.HEADER_OUT, bus.DATA_OUT_VALID);
        end
        checks++;
        if (bus.DATA_IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b exp 0", bus.DATA_IN_READY);
        end
    endtask

    task automatic test_frame;
        SYSTEM_RESET = 1'b0;
        bus.PASSTHROUGH = 1'b0;
        tick;
        checks++;
        if (bus.DATA_OUT !== SYNC || bus.HEADER_OUT !== 2'b10 || bus.DATA_OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL first_sync got %h/%b/%b exp %h/10/1", bus.DATA_OUT, bus.HEADER_OUT, bus.DATA_OUT_VALID, SYNC);
        end
        checks++;
        if (bus.DATA_IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_state got %b exp 0", bus.DATA_IN_READY);
        end
        tick;
        checks++;
        if (bus.DATA_OUT !== STATE0 || bus.HEADER_OUT !== 2'b10 || bus.DATA_OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL first_state got %h/%b exp %h/10", bus.DATA_OUT, bus.HEADER_OUT, STATE0);
        end
        mscr = bus.DATA_OUT[57:0];
        checks++;
        if (bus.DATA_IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_payload got %b exp 1", bus.DATA_IN_READY);
        end
        for (int k = 0; k < 14; k++)
            payload_word(64'h0123_4567_0000_0000 + 64'(k), k[0] ? 2'b01 : 2'b10);
        tick;
        checks++;
        if (bus.DATA_OUT !== SYNC || bus.HEADER_OUT !== 2'b10 || bus.DATA_OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL word16_sync got %h exp %h", bus.DATA_OUT, SYNC);
        end
        tick;
        checks++;
        if (bus.DATA_OUT !== {6'b001010, mscr}) begin
            errors++;
            $display("FAIL state_continuity got %h exp %h", bus.DATA_OUT, {6'b001010, mscr});
        end
    endtask

    task automatic test_gaps;
        int acc = 0;
        logic v = 1'b1;
        for (int c = 0; c < 40 && acc < 14; c++) begin
            bus.DATA_IN = 64'hA5A5_0000_0000_0000 + 64'(acc);
            bus.HEADER_IN = 2'b01;
            bus.DATA_IN_VALID = v;
            sent = bus.DATA_IN;
            tick;
            checks++;
            if (bus.DATA_OUT_VALID !== v) begin
                errors++;
                $display("FAIL gap_valid got %b exp %b", bus.DATA_OUT_VALID, v);
            end
            if (v) begin
                descramble(bus.DATA_OUT, got);
                acc++;
                checks++;
                if (got !== sent) begin
                    errors++;
                    $display("FAIL gap_payload got %h exp %h", got, sent);
                end
            end
            v = ~v;
        end
        checks++;
        if (acc != 14) begin
            errors++;
            $display("FAIL gap_accepted got %0d exp 14", acc);
        end
        bus.DATA_IN_VALID = 1'b0;
        tick;
        checks++;
        if (bus.DATA_OUT !== SYNC || bus.DATA_OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL gap_sync got %h/%b exp %h/1", bus.DATA_OUT, bus.DATA_OUT_VALID, SYNC);
        end
        tick;
        checks++;
        if (bus.DATA_OUT !== {6'b001010, mscr}) begin
            errors++;
            $display("FAIL gap_state got %h exp %h", bus.DATA_OUT, {6'b001010, mscr});
        end
    endtask

    task automatic test_passthrough;
        for (int k = 0; k < 3; k++)
            payload_word(64'h5555_AAAA_0000_0000 + 64'(k), 2'b01);
        bus.PASSTHROUGH = 1'b1;
        for (int p = 0; p < 5; p++) begin
            bus.DATA_IN = {32'hFEED_0000 + 32'(p), 32'h1234_5678};
            bus.HEADER_IN = 2'b11;
            bus.DATA_IN_VALID = 1'b1;
            sent = bus.DATA_IN;
            checks++;
            if (bus.DATA_IN_READY !== 1'b1) begin
                errors++;
                $display("FAIL pass_ready got %b exp 1", bus.DATA_IN_READY);
            end
            tick;
            checks++;
            if (bus.DATA_OUT !== sent || bus.HEADER_OUT !== 2'b11 || bus.DATA_OUT_VALID !== 1'b1) begin
                errors++;
                $display("FAIL pass_word got %h/%b exp %h/11", bus.DATA_OUT, bus.HEADER_OUT, sent);
            end
        end
        bus.PASSTHROUGH = 1'b0;
        tick;
        checks++;
        if (bus.DATA_OUT !== SYNC || bus.HEADER_OUT !== 2'b10) begin
            errors++;
            $display("FAIL pass_exit_sync got %h exp %h", bus.DATA_OUT, SYNC);
        end
        tick;
        checks++;
        if (bus.DATA_OUT !== {6'b001010, mscr}) begin
            errors++;
            $display("FAIL pass_scr_held got %h exp %h", bus.DATA_OUT, {6'b001010, mscr});
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 7; k++)
            payload_word(64'hC0DE_0000_0000_0000 + 64'(k), 2'b10);
        SYSTEM_RESET = 1'b1;
        tick;
        checks++;
        if (bus.DATA_OUT_VALID !== 1'b0 || bus.DATA_OUT !== 64'd0 || bus.DATA_IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL midreset got %h/%b/%b exp 0/0/0", bus.DATA_OUT, bus.DATA_OUT_VALID, bus.DATA_IN_READY);
        end
        SYSTEM_RESET = 1'b0;
        tick;
        checks++;
        if (bus.DATA_OUT !== SYNC || bus.DATA_OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL midreset_sync got %h exp %h", bus.DATA_OUT, SYNC);
        end
        tick;
        checks++;
        if (bus.DATA_OUT !== STATE0) begin
            errors++;
            $display("FAIL midreset_state got %h exp %h", bus.DATA_OUT, STATE0);
        end
        mscr = bus.DATA_OUT[57:0];
    endtask

`ifdef METAFRAME_SCRAMBLER_ERR_INJECT_EN
    task automatic test_inject;
        INJECT_SYNC_ERR = 1'b1;
        payload_word(64'h1111_0000_0000_0000, 2'b01);
        INJECT_SYNC_ERR = 1'b0;
        for (int k = 1; k < 14; k++)
            payload_word(64'h1111_0000_0000_0000 + 64'(k), 2'b01);
        tick;
        checks++;
        if (bus.DATA_OUT !== 64'h78f678f678f678f7) begin
            errors++;
            $display("FAIL inject_sync got %h exp 78f678f678f678f7", bus.DATA_OUT);
        end
        tick;
        for (int k = 0; k < 14; k++)
            payload_word(64'h2222_0000_0000_0000 + 64'(k), 2'b01);
        tick;
        checks++;
        if (bus.DATA_OUT !== SYNC) begin
            errors++;
            $display("FAIL inject_cleared got %h exp %h", bus.DATA_OUT, SYNC);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_frame;
        test_gaps;
        test_passthrough;
        test_reset_mid;
`ifdef METAFRAME_SCRAMBLER_ERR_INJECT_EN
        test_inject;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
